// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: debounced button front-end and MENU/PLAY/PAUSE/OVER mode machine driving the VGA screen mux.
// Optional menu auto-repeat is enabled by defining GAME_MODE_CTRL_AUTOREPEAT_EN.
module game_mode_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_CHOICES  = 4,
  parameter int CHOICE_W     = 2,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 15000000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [4*NUM_PLAYERS-1:0] btn_raw,
  input  logic                     exit_raw,
  input  logic                     pause_raw,
  input  logic                     game_over,
  output logic [1:0]               vga_mux,
  output logic [CHOICE_W-1:0]      choice,
  output logic [4*NUM_PLAYERS-1:0] play_btn,
  output logic                     game_start
);
  localparam int NB       = 4*NUM_PLAYERS+2;
  localparam int IX_EXIT  = 4*NUM_PLAYERS;
  localparam int IX_PAUSE = 4*NUM_PLAYERS+1;
  localparam int CW       = $clog2(DEBOUNCE_CYC+1);
  localparam logic [CW-1:0]       DB_LAST  = CW'(DEBOUNCE_CYC-1);
  localparam logic [CHOICE_W-1:0] CH_LAST  = CHOICE_W'(NUM_CHOICES-1);
  typedef enum logic [1:0] {S_MENU = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3} state_t;
  state_t r_state, w_next;
  logic [NB-1:0] w_raw, r_s1, r_s2, r_stable, r_stable_d, w_pulse;
  logic [CW-1:0] r_cnt [NB];
  logic [1:0] r_vga;
  logic [CHOICE_W-1:0] r_choice, w_choice_nxt;
  logic r_start, w_step_up, w_step_dn;
  assign w_raw   = {pause_raw, exit_raw, btn_raw};
  assign w_pulse = r_stable & ~r_stable_d;
  // Counter runs only while the synced level disagrees with the accepted level.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= w_raw;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      for (int i = 0; i < NB; i++)
        if (r_s2[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DB_LAST) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= r_s2[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MENU:  w_next = w_pulse[1] ? S_PLAY : S_MENU;
      S_PLAY:  w_next = w_pulse[IX_EXIT] ? S_MENU : game_over ? S_OVER : w_pulse[IX_PAUSE] ? S_PAUSE : S_PLAY;
      S_PAUSE: w_next = w_pulse[IX_EXIT] ? S_MENU : w_pulse[IX_PAUSE] ? S_PLAY : S_PAUSE;
      default: w_next = w_pulse[IX_EXIT] ? S_MENU : w_pulse[1] ? S_PLAY : S_OVER;
    endcase
  end
`ifdef GAME_MODE_CTRL_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX+1);
  logic [RW-1:0] r_rep;
  logic r_first, w_held, w_tick;
  assign w_held = (r_state == S_MENU) && (w_next == r_state) && (r_stable[2] | r_stable[3]);
  assign w_tick = w_held && (r_rep == (r_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_rep   <= '0;
      r_first <= 1'b1;
    end else if (!w_held) begin
      r_rep   <= '0;
      r_first <= 1'b1;
    end else if (w_tick) begin
      r_rep   <= RW'(1);
      r_first <= 1'b0;
    end else r_rep <= r_rep + 1'b1;
  assign w_step_up = w_pulse[2] | (w_tick & r_stable[2]);
  assign w_step_dn = w_pulse[3] | (w_tick & r_stable[3]);
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  assign w_step_up = w_pulse[2];
  assign w_step_dn = w_pulse[3];
`endif
  always_comb begin
    w_choice_nxt = r_choice;
    if (r_state == S_MENU && w_step_up && !w_step_dn) w_choice_nxt = (r_choice == '0) ? CH_LAST : r_choice - 1'b1;
    if (r_state == S_MENU && w_step_dn && !w_step_up) w_choice_nxt = (r_choice == CH_LAST) ? '0 : r_choice + 1'b1;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_state  <= S_MENU;
      r_vga    <= 2'd0;
      r_choice <= '0;
      r_start  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_vga    <= 2'(w_next);
      r_choice <= w_choice_nxt;
      r_start  <= (w_next == S_PLAY) && (r_state == S_MENU || r_state == S_OVER);
    end
  assign vga_mux    = r_vga;
  assign choice     = r_choice;
  assign game_start = r_start;
  assign play_btn   = (r_state == S_PLAY) ? w_pulse[4*NUM_PLAYERS-1:0] : '0;
endmodule

// File: tb/tb_game_mode_ctrl.sv
// tb_game_mode_ctrl: directed checks of debounce timing, menu wrap, mode transitions and async reset.
module tb_game_mode_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] btn = '0;
  logic exit_r = 1'b0, pause_r = 1'b0, gover = 1'b0;
  logic [1:0] vga, choice;
  logic [7:0] pbtn;
  logic gstart;
  int n_chk = 0, n_fail = 0;
  int n_start = 0, n_p4 = 0, n_steps = 0;
  int b0;
  logic [1:0] prev_choice = 2'd0;
  always #5 clk = ~clk;
  game_mode_ctrl #(
    .NUM_PLAYERS(2), .NUM_CHOICES(3), .CHOICE_W(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .btn_raw(btn), .exit_raw(exit_r), .pause_raw(pause_r),
    .game_over(gover), .vga_mux(vga), .choice(choice), .play_btn(pbtn), .game_start(gstart)
  );
  always @(negedge clk) begin
    if (gstart) n_start++;
    if (pbtn[4]) n_p4++;
    if (choice !== prev_choice) n_steps++;
    prev_choice = choice;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_raw(input int idx, input logic v);
    if (idx < 8) btn[idx] = v;
    else if (idx == 8) exit_r = v;
    else pause_r = v;
  endtask
  task automatic press(input int idx, input int hold);
    set_raw(idx, 1'b1);
    tick(hold);
    set_raw(idx, 1'b0);
    tick(12);
  endtask
  initial begin
    tick(3);
    chk("rst_vga", vga, 0);
    chk("rst_choice", choice, 0);
    chk("rst_play_btn", pbtn, 0);
    chk("rst_game_start", gstart, 0);
    rst_n = 1'b1;
    tick(2);
    b0 = n_steps;
    press(2, 10);
    chk("up_wrap", choice, 2);
    chk("up_single_step", n_steps - b0, 1);
    chk("menu_vga", vga, 0);
    press(2, 10);
    chk("up_again", choice, 1);
    press(3, 10);
    chk("down_1", choice, 2);
    press(3, 10);
    chk("down_wrap", choice, 0);
    set_raw(3, 1'b1);
    tick(3);
    set_raw(3, 1'b0);
    tick(8);
    chk("glitch_ignored", choice, 0);
    set_raw(3, 1'b1);
    tick(6);
    chk("latency_not_yet", choice, 0);
    tick(1);
    chk("latency_at_7", choice, 1);
    tick(1);
    set_raw(3, 1'b0);
    tick(12);
    chk("release_no_step", choice, 1);
    b0 = n_start;
    set_raw(1, 1'b1);
    tick(7);
    chk("right_to_play", vga, 1);
    chk("start_high", gstart, 1);
    tick(1);
    chk("start_one_cycle", gstart, 0);
    set_raw(1, 1'b0);
    tick(12);
    chk("start_count", n_start - b0, 1);
    b0 = n_p4;
    press(4, 8);
    chk("p1_left_in_play", n_p4 - b0, 1);
    press(3, 8);
    chk("choice_frozen_play", choice, 1);
    set_raw(8, 1'b1);
    tick(6);
    gover = 1'b1;
    tick(1);
    chk("exit_beats_over", vga, 0);
    gover = 1'b0;
    set_raw(8, 1'b0);
    tick(12);
    chk("exit_stays_menu", vga, 0);
    b0 = n_p4;
    press(4, 8);
    chk("p1_left_in_menu", n_p4 - b0, 0);
    press(1, 8);
    chk("replay", vga, 1);
    gover = 1'b1;
    tick(2);
    chk("game_over", vga, 3);
    gover = 1'b0;
    b0 = n_start;
    press(1, 8);
    chk("over_restart", vga, 1);
    chk("over_restart_pulse", n_start - b0, 1);
    chk("over_same_choice", choice, 1);
    press(9, 8);
    chk("pause", vga, 2);
    b0 = n_p4;
    press(4, 8);
    chk("no_btn_in_pause", n_p4 - b0, 0);
    gover = 1'b1;
    tick(3);
    chk("pause_ignores_over", vga, 2);
    gover = 1'b0;
    b0 = n_start;
    press(9, 8);
    chk("resume", vga, 1);
    chk("resume_no_start", n_start - b0, 0);
    press(9, 8);
    chk("pause_again", vga, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vga", vga, 0);
    chk("async_rst_choice", choice, 0);
    chk("async_rst_start", gstart, 0);
    chk("async_rst_play_btn", pbtn, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_vga", vga, 0);
    b0 = n_steps;
    set_raw(3, 1'b1);
    tick(34);
    set_raw(3, 1'b0);
    tick(12);
`ifdef GAME_MODE_CTRL_AUTOREPEAT_EN
    chk("repeat_steps", n_steps - b0, 3);
    chk("repeat_choice", choice, 0);
`else
    chk("hold_single_step", n_steps - b0, 1);
    chk("hold_choice", choice, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
